// File: rtl/neuron_seq_pkg.sv
// Shared types and constants for the neuron load/run sequencer: FSM states,
// per-neuron field order and watchdog limits.
package neuron_seq_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned TIMEOUT_WR  = 255;
    localparam int unsigned TIMEOUT_RUN = 65535;

    typedef enum logic [2:0] {IDLE, LOAD, RUNLEN, RUN, READ} state_e;
    typedef enum logic [1:0] {VMEM, MU, NEURONI, Q} field_e;

    // Fields are always programmed VMEM -> MU -> NEURONI -> Q, then wrap.
    function automatic field_e next_field(input field_e f);
        case (f)
            VMEM:    return MU;
            MU:      return NEURONI;
            NEURONI: return Q;
            default: return VMEM;
        endcase
    endfunction

endpackage

// File: rtl/spike_word_packer.sv
// Holds the end-of-run spike snapshot and presents readout word k, with every
// bit at or beyond the active neuron count forced to zero.
module spike_word_packer
    import neuron_seq_pkg::*;
#(
    parameter int NUM_NEURON      = 512,
    parameter int NEURON_ID_WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         snap_en_i,
    input  logic [NUM_NEURON-1:0]        spike_state_i,
    input  logic [NEURON_ID_WIDTH:0]     active_n_i,
    input  logic [NEURON_ID_WIDTH-4:0]   word_idx_i,
    output logic [WORD_W-1:0]            word_o
);

    localparam int IDX_W = NEURON_ID_WIDTH + 1;
    localparam int WSH   = $clog2(WORD_W);

    logic [NUM_NEURON-1:0] snap_q;
    logic [IDX_W-1:0]      base;
    logic [IDX_W-1:0]      idx;

    // NOTE: the snapshot is wide but still reset, so rd_data reads 0 out of
    // reset instead of whatever the flops powered up with.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q <= '0;
        end else if (snap_en_i) begin
            snap_q <= spike_state_i;
        end
    end

    assign base = {word_idx_i, {WSH{1'b0}}};

    always_comb begin
        word_o = '0;
        idx    = '0;
        for (int i = 0; i < WORD_W; i++) begin
            idx = base + IDX_W'(i);
            // idx < N <= NUM_NEURON, so the truncated index is always in range.
            if (idx < active_n_i) begin
                word_o[i] = snap_q[idx[NEURON_ID_WIDTH-1:0]];
            end
        end
    end

endmodule

// File: rtl/neuron_load_run_sequencer.sv
// Host-facing load/run/readout sequencer for the neuron array.
// Optional watchdog on stalled writes and stalled runs: `define NEURON_SEQ_TIMEOUT_EN.
module neuron_load_run_sequencer
    import neuron_seq_pkg::*;
#(
    parameter int FP_DATA_WIDTH   = 16,
    parameter int TEN_DATA_WIDTH  = 2,
    parameter int NUM_NEURON      = 512,
    parameter int NEURON_ID_WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [FP_DATA_WIDTH-1:0]     host_data,
    input  logic                         host_valid,
    output logic                         host_ready,
    output logic [NEURON_ID_WIDTH-1:0]   neuron_sel,
    output logic                         wr_vmem,
    output logic                         wr_mu,
    output logic                         wr_neuronI,
    output logic                         wr_q,
    output logic [FP_DATA_WIDTH-1:0]     wr_data,
    input  logic                         wr_done,
    output logic                         run_en,
    input  logic                         network_done,
    input  logic [NUM_NEURON-1:0]        spike_state,
    output logic [FP_DATA_WIDTH-1:0]     rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [NEURON_ID_WIDTH:0]     active_count,
    output logic                         busy,
    output logic                         cfg_err
);

    localparam int CNT_W  = NEURON_ID_WIDTH + 1;
    localparam int WCNT_W = NEURON_ID_WIDTH - 3;

    state_e                   state_q, state_d;
    field_e                   field_q, field_d;
    logic [CNT_W-1:0]         sel_q, sel_d;
    logic [CNT_W-1:0]         n_q, n_d;
    logic [15:0]              epoch_q, epoch_d;
    logic [WCNT_W-1:0]        word_q, word_d;
    logic                     pending_q, pending_d;
    logic [FP_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                     cfg_err_q, cfg_err_d;
    logic                     rd_valid_q, rd_valid_d;
    logic                     snap_en;
`ifdef NEURON_SEQ_TIMEOUT_EN
    logic [15:0]              wd_q, wd_d;
`endif

    logic [CNT_W-1:0]  hdr_n;
    logic [CNT_W-1:0]  n_minus1;
    logic [WCNT_W-1:0] last_word;

    assign hdr_n     = host_data[NEURON_ID_WIDTH:0];
    assign n_minus1  = n_q - CNT_W'(1);
    assign last_word = n_minus1[CNT_W-1 -: WCNT_W];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            field_q    <= VMEM;
            sel_q      <= '0;
            n_q        <= '0;
            epoch_q    <= '0;
            word_q     <= '0;
            pending_q  <= 1'b0;
            wr_data_q  <= '0;
            cfg_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
`ifdef NEURON_SEQ_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            field_q    <= field_d;
            sel_q      <= sel_d;
            n_q        <= n_d;
            epoch_q    <= epoch_d;
            word_q     <= word_d;
            pending_q  <= pending_d;
            wr_data_q  <= wr_data_d;
            cfg_err_q  <= cfg_err_d;
            rd_valid_q <= rd_valid_d;
`ifdef NEURON_SEQ_TIMEOUT_EN
            wd_q       <= wd_d;
`endif
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        field_d    = field_q;
        sel_d      = sel_q;
        n_d        = n_q;
        epoch_d    = epoch_q;
        word_d     = word_q;
        pending_d  = pending_q;
        wr_data_d  = wr_data_q;
        cfg_err_d  = cfg_err_q;
        rd_valid_d = rd_valid_q;
        snap_en    = 1'b0;
        host_ready = 1'b0;
`ifdef NEURON_SEQ_TIMEOUT_EN
        wd_d       = '0;
`endif
        case (state_q)
            IDLE: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    if (hdr_n == '0 || hdr_n > CNT_W'(NUM_NEURON)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        n_d       = hdr_n;
                        cfg_err_d = 1'b0;
                        sel_d     = '0;
                        field_d   = VMEM;
                        state_d   = LOAD;
                    end
                end
            end
            LOAD: begin
                host_ready = !pending_q;
                if (!pending_q) begin
                    if (host_valid) begin
                        pending_d = 1'b1;
                        // Narrow fields are latched zero-extended so the array sees clean data.
                        case (field_q)
                            Q:       wr_data_d = FP_DATA_WIDTH'(host_data[TEN_DATA_WIDTH-1:0]);
                            NEURONI: wr_data_d = FP_DATA_WIDTH'(host_data[NEURON_ID_WIDTH-1:0]);
                            default: wr_data_d = host_data;
                        endcase
                    end
                end else if (wr_done) begin
                    pending_d = 1'b0;
                    field_d   = next_field(field_q);
                    if (field_q == Q) begin
                        if (sel_q == n_minus1) begin
                            sel_d   = '0;
                            state_d = RUNLEN;
                        end else begin
                            sel_d = sel_q + CNT_W'(1);
                        end
                    end
                end
`ifdef NEURON_SEQ_TIMEOUT_EN
                else if (wd_q == 16'(TIMEOUT_WR - 1)) begin
                    pending_d = 1'b0;
                    cfg_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
`endif
            end
            RUNLEN: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    epoch_d = host_data[15:0];
                    word_d  = '0;
                    if (host_data[15:0] == 16'd0) begin
                        snap_en = 1'b1;
                        state_d = READ;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (network_done) begin
                    epoch_d = epoch_q - 16'd1;
                    if (epoch_q == 16'd1) begin
                        snap_en = 1'b1;
                        state_d = READ;
                    end
                end
`ifdef NEURON_SEQ_TIMEOUT_EN
                else if (wd_q == 16'(TIMEOUT_RUN - 1)) begin
                    cfg_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
`endif
            end
            READ: begin
                if (!rd_valid_q) begin
                    rd_valid_d = 1'b1;
                end else if (rd_ready) begin
                    if (word_q == last_word) begin
                        rd_valid_d = 1'b0;
                        word_d     = '0;
                        state_d    = IDLE;
                    end else begin
                        word_d = word_q + WCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    spike_word_packer #(
        .NUM_NEURON      (NUM_NEURON),
        .NEURON_ID_WIDTH (NEURON_ID_WIDTH)
    ) u_packer (
        .clk           (clk),
        .reset         (reset),
        .snap_en_i     (snap_en),
        .spike_state_i (spike_state),
        .active_n_i    (n_q),
        .word_idx_i    (word_q),
        .word_o        (rd_data)
    );

    assign wr_vmem      = pending_q && (field_q == VMEM);
    assign wr_mu        = pending_q && (field_q == MU);
    assign wr_neuronI   = pending_q && (field_q == NEURONI);
    assign wr_q         = pending_q && (field_q == Q);
    assign wr_data      = wr_data_q;
    assign neuron_sel   = sel_q[NEURON_ID_WIDTH-1:0];
    assign run_en       = (state_q == RUN);
    assign busy         = (state_q != IDLE);
    assign active_count = n_q;
    assign cfg_err      = cfg_err_q;
    assign rd_valid     = rd_valid_q;

endmodule
